csr_stream_fetch: RTL and testbench

- Upstream feeder for the SpMV engine. Walks a CSR matrix held in external synchronous-read memories: a row-pointer array plus nonzero value and column arrays.
- Emits one beat per nonzero on a valid/ready stream carrying value, column, row index and an end-of-row flag.
- Replaces the free-running counter and address sequencing that currently drive the value, column and EOR BRAMs.
- Handles backpressure, empty rows and malformed row pointers.

---
 rtl/spmv_pkg.sv | 30 +++
 rtl/csr_stream_fetch_if.sv | 50 +++++
 rtl/sync_fifo.sv | 52 +++++
 rtl/csr_stream_fetch.sv | 192 +++++++++++++++++++
 tb/tb_csr_stream_fetch.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spmv_pkg.sv
// spmv_pkg: shared definitions for the SpMV front end.
//   - default field widths and output FIFO depth
//   - fetch FSM state encoding
//   - stream beat layout {val, col, row, eor}
package spmv_pkg;

    localparam int DEF_WIDTH_VALUE = 16;
    localparam int DEF_WIDTH_COL   = 16;
    localparam int DEF_WIDTH_ROW   = 16;
    localparam int DEF_WIDTH_PTR   = 20;
    localparam int DEF_FIFO_DEPTH  = 4;

    typedef enum logic [2:0] {
        IDLE,
        PTR0_REQ,
        PTR0_WAIT,
        PTR_REQ,
        PTR_WAIT,
        STREAM,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [DEF_WIDTH_VALUE-1:0] val;
        logic [DEF_WIDTH_COL-1:0]   col;
        logic [DEF_WIDTH_ROW-1:0]   row;
        logic                       eor;
    } beat_t;

endpackage

// File: rtl/csr_stream_fetch_if.sv
// csr_stream_fetch_if: all non-clock signals of the CSR fetcher.
//   control : start, n_rows -> busy, done, ptr_err
//   rp mem  : rp_en, rp_addr -> rp_data (1-cycle read latency)
//   nz mem  : nz_en, nz_addr -> nz_val, nz_col (1-cycle read latency)
//   stream  : out_valid, out_val, out_col, out_row, out_eor <- out_ready
// master = the fetcher, slave = its environment (memories, controller, sink).
interface csr_stream_fetch_if
    import spmv_pkg::*;
#(
    parameter int WIDTH_VALUE = DEF_WIDTH_VALUE,
    parameter int WIDTH_COL   = DEF_WIDTH_COL,
    parameter int WIDTH_ROW   = DEF_WIDTH_ROW,
    parameter int WIDTH_PTR   = DEF_WIDTH_PTR
) ();

    logic                   start;
    logic [WIDTH_ROW-1:0]   n_rows;
    logic                   busy;
    logic                   done;
    logic                   ptr_err;

    logic                   rp_en;
    logic [WIDTH_ROW-1:0]   rp_addr;
    logic [WIDTH_PTR-1:0]   rp_data;

    logic                   nz_en;
    logic [WIDTH_PTR-1:0]   nz_addr;
    logic [WIDTH_VALUE-1:0] nz_val;
    logic [WIDTH_COL-1:0]   nz_col;

    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH_VALUE-1:0] out_val;
    logic [WIDTH_COL-1:0]   out_col;
    logic [WIDTH_ROW-1:0]   out_row;
    logic                   out_eor;

    modport master (
        input  start, n_rows, rp_data, nz_val, nz_col, out_ready,
        output busy, done, ptr_err, rp_en, rp_addr, nz_en, nz_addr,
               out_valid, out_val, out_col, out_row, out_eor
    );

    modport slave (
        output start, n_rows, rp_data, nz_val, nz_col, out_ready,
        input  busy, done, ptr_err, rp_en, rp_addr, nz_en, nz_addr,
               out_valid, out_val, out_col, out_row, out_eor
    );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH a power of two (>= 2).
//   push/wdata  : write side; a push while full is taken only with a pop
//   pop/rdata   : read side; rdata is the head entry (show-ahead)
//   count/full/empty : occupancy
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/csr_stream_fetch.sv
// csr_stream_fetch: walks a CSR matrix (row pointers + value/column arrays
// in synchronous-read memories) and emits one stream beat per nonzero,
// tagged with its row and an end-of-row flag. Empty rows, and rows whose
// pointer goes backwards (flagged on ptr_err), emit one synthetic beat
// {val=0, col=r, row=r, eor=1} so every row closes with an eor beat.
//   clk, rst_n : clock, async active-low reset
//   bus        : csr_stream_fetch_if.master (control, rp/nz memories, stream)
module csr_stream_fetch
    import spmv_pkg::*;
#(
    parameter int WIDTH_VALUE = DEF_WIDTH_VALUE,
    parameter int WIDTH_COL   = DEF_WIDTH_COL,
    parameter int WIDTH_ROW   = DEF_WIDTH_ROW,
    parameter int WIDTH_PTR   = DEF_WIDTH_PTR,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input logic               clk,
    input logic               rst_n,
    csr_stream_fetch_if.master bus
);

    typedef struct packed {
        logic [WIDTH_VALUE-1:0] val;
        logic [WIDTH_COL-1:0]   col;
        logic [WIDTH_ROW-1:0]   row;
        logic                   eor;
    } fifo_beat_t;

    localparam int                   CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]       DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [WIDTH_ROW-1:0] ROW_ONE = 1;
    localparam logic [WIDTH_PTR-1:0] PTR_ONE = 1;

    state_t               state, state_d;
    logic [WIDTH_ROW-1:0] n_rows_q, r, tag_row;
    logic [WIDTH_PTR-1:0] k, row_end;
    logic                 inflight, tag_eor;
    logic                 busy_q, done_q, ptr_err_q;

    logic                 credit, issue_rd, push_syn, row_done, last_row, drained;
    logic                 rp_en, nz_en;
    logic [WIDTH_ROW-1:0] rp_addr;
    logic [WIDTH_PTR-1:0] nz_addr;

    fifo_beat_t           fifo_wdata, fifo_rdata;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;

    // Reserve a slot for the read in flight so a returning beat always fits.
    assign credit   = ~fifo_full &
                      (({1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight}) < DEPTH_C);
    assign last_row = ((r + ROW_ONE) == n_rows_q);
    assign drained  = fifo_empty & ~inflight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d  = state;
        rp_en    = 1'b0;
        rp_addr  = '0;
        nz_en    = 1'b0;
        nz_addr  = '0;
        issue_rd = 1'b0;
        push_syn = 1'b0;
        row_done = 1'b0;
        case (state)
            IDLE:      if (bus.start && bus.n_rows != '0) state_d = PTR0_REQ;
            PTR0_REQ:  begin rp_en = 1'b1; state_d = PTR0_WAIT; end
            PTR0_WAIT: state_d = PTR_REQ;
            PTR_REQ:   begin rp_en = 1'b1; rp_addr = r + ROW_ONE; state_d = PTR_WAIT; end
            PTR_WAIT:  state_d = STREAM;
            STREAM: begin
                if (credit) begin
                    // A row is left right after its eor beat, so k==row_end
                    // here only happens for a row that is empty on entry.
                    if (k != row_end) begin
                        nz_en    = 1'b1;
                        nz_addr  = k;
                        issue_rd = 1'b1;
                        row_done = ((k + PTR_ONE) == row_end);
                    end else begin
                        push_syn = 1'b1;
                        row_done = 1'b1;
                    end
                    if (row_done) state_d = last_row ? DRAIN : PTR_REQ;
                end
            end
            DRAIN:     if (drained) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_rows_q  <= '0;
            r         <= '0;
            k         <= '0;
            row_end   <= '0;
            inflight  <= 1'b0;
            tag_row   <= '0;
            tag_eor   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ptr_err_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            inflight <= issue_rd;
            if (state == IDLE && bus.start) begin
                if (bus.n_rows == '0) begin
                    done_q <= 1'b1;
                end else begin
                    n_rows_q  <= bus.n_rows;
                    r         <= '0;
                    ptr_err_q <= 1'b0;
                    busy_q    <= 1'b1;
                end
            end
            if (state == PTR0_WAIT) k <= bus.rp_data;
            // k already holds the row start (previous row's end), so rp[r]
            // is never re-read; a backwards pointer collapses to an empty row.
            if (state == PTR_WAIT) begin
                if (bus.rp_data < k) begin
                    ptr_err_q <= 1'b1;
                    row_end   <= k;
                end else begin
                    row_end   <= bus.rp_data;
                end
            end
            if (issue_rd) begin
                k       <= k + PTR_ONE;
                tag_row <= r;
                tag_eor <= row_done;
            end
            if (row_done) r <= r + ROW_ONE;
            if (state == DRAIN && drained) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    // Returning read and synthetic beat never coincide: two pointer cycles
    // separate the last read of one row from the next row's STREAM entry.
    always_comb begin
        fifo_wdata = '0;
        if (inflight) begin
            fifo_wdata.val = bus.nz_val;
            fifo_wdata.col = bus.nz_col;
            fifo_wdata.row = tag_row;
            fifo_wdata.eor = tag_eor;
        end else begin
            fifo_wdata.col = WIDTH_COL'(r);
            fifo_wdata.row = r;
            fifo_wdata.eor = 1'b1;
        end
    end

    assign fifo_push = inflight | push_syn;
    assign fifo_pop  = ~fifo_empty & bus.out_ready;

    sync_fifo #(
        .WIDTH ($bits(fifo_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ptr_err   = ptr_err_q;
    assign bus.rp_en     = rp_en;
    assign bus.rp_addr   = rp_addr;
    assign bus.nz_en     = nz_en;
    assign bus.nz_addr   = nz_addr;
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_val   = fifo_rdata.val;
    assign bus.out_col   = fifo_rdata.col;
    assign bus.out_row   = fifo_rdata.row;
    assign bus.out_eor   = fifo_rdata.eor;

endmodule

// File: tb/tb_csr_stream_fetch.sv
// tb_csr_stream_fetch: directed bench for csr_stream_fetch. A CSR walk model
// builds the expected beat list from the memory contents; a negedge monitor
// checks every accepted beat against it and holds out_* steady under stall.
module tb_csr_stream_fetch;
    import spmv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csr_stream_fetch_if bus ();

    csr_stream_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [19:0] rp_mem  [16];
    logic [15:0] val_mem [16];
    logic [15:0] col_mem [16];

    always @(posedge clk) begin
        if (bus.rp_en) bus.rp_data <= rp_mem[bus.rp_addr[3:0]];
        if (bus.nz_en) begin
            bus.nz_val <= val_mem[bus.nz_addr[3:0]];
            bus.nz_col <= col_mem[bus.nz_addr[3:0]];
        end
    end

    int    errors = 0;
    int    checks = 0;
    bit    chk_en = 1'b0;
    int    done_cnt = 0;
    int    acc = 0;
    bit    stalled = 1'b0;
    beat_t held;
    beat_t cur;
    beat_t expq[$];
    beat_t got[$];

    localparam beat_t LIT1[5] = '{'{16'd5, 16'd0, 16'd0, 1'b0}, '{16'd7, 16'd2, 16'd0, 1'b1},
                                  '{16'd3, 16'd1, 16'd1, 1'b1}, '{16'd7, 16'd0, 16'd2, 1'b0},
                                  '{16'd9, 16'd2, 16'd2, 1'b1}};
    localparam beat_t LIT3[3] = '{'{16'd4, 16'd0, 16'd0, 1'b1}, '{16'd0, 16'd1, 16'd1, 1'b1},
                                  '{16'd6, 16'd2, 16'd2, 1'b1}};
    localparam beat_t SYN_BAD = '{16'd0, 16'd1, 16'd1, 1'b1};

    assign cur = {bus.out_val, bus.out_col, bus.out_row, bus.out_eor};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // CSR walk: row r covers [start, rp[r+1]); a backwards pointer is an empty
    // row; an empty row yields one synthetic beat carrying col=row=r.
    task automatic build_exp(input int n, output bit err);
        int    s, e;
        beat_t b;
        expq.delete();
        err = 1'b0;
        s = int'(rp_mem[0]);
        for (int rr = 0; rr < n; rr++) begin
            e = int'(rp_mem[rr + 1]);
            if (e < s) begin err = 1'b1; e = s; end
            if (e == s) begin
                b.val = '0; b.col = 16'(rr); b.row = 16'(rr); b.eor = 1'b1;
                expq.push_back(b);
            end else begin
                for (int kk = s; kk < e; kk++) begin
                    b.val = val_mem[kk]; b.col = col_mem[kk];
                    b.row = 16'(rr);     b.eor = (kk == e - 1);
                    expq.push_back(b);
                end
            end
            s = e;
        end
    endtask

    task automatic load(input int m);
        for (int i = 0; i < 16; i++) begin
            rp_mem[i] = '0; val_mem[i] = '0; col_mem[i] = '0;
        end
        case (m)
            0: begin
                rp_mem[0] = 20'd0; rp_mem[1] = 20'd2; rp_mem[2] = 20'd3; rp_mem[3] = 20'd5;
                val_mem[0] = 16'd5; val_mem[1] = 16'd7; val_mem[2] = 16'd3; val_mem[3] = 16'd7; val_mem[4] = 16'd9;
                col_mem[0] = 16'd0; col_mem[1] = 16'd2; col_mem[2] = 16'd1; col_mem[3] = 16'd0; col_mem[4] = 16'd2;
            end
            1: begin
                rp_mem[0] = 20'd0; rp_mem[1] = 20'd1; rp_mem[2] = 20'd1; rp_mem[3] = 20'd2;
                val_mem[0] = 16'd4; val_mem[1] = 16'd6;
                col_mem[0] = 16'd0; col_mem[1] = 16'd2;
            end
            default: begin
                rp_mem[0] = 20'd0; rp_mem[1] = 20'd3; rp_mem[2] = 20'd1; rp_mem[3] = 20'd4;
                val_mem[0] = 16'd1; val_mem[1] = 16'd2; val_mem[2] = 16'd3; val_mem[3] = 16'd4;
                col_mem[0] = 16'd0; col_mem[1] = 16'd1; col_mem[2] = 16'd2; col_mem[3] = 16'd0;
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (bus.done) begin
                done_cnt++;
                chk("done_after_last_beat", 64'(expq.size()), 64'd0);
            end
            if (stalled) begin
                chk("stall_valid_held", 64'(bus.out_valid), 64'd1);
                chk("stall_beat_held", 64'(cur), 64'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) chk("extra_beat", 64'd1, 64'd0);
                else                  chk("beat", 64'(cur), 64'(expq.pop_front()));
                got.push_back(cur);
                acc++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = cur;
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic run_pass(input int n, input bit tog);
        bit err;
        int cyc;
        build_exp(n, err);
        got.delete();
        done_cnt = 0;
        acc = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.n_rows = 16'(n); bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        cyc = 0;
        while (!bus.done && cyc < 400) begin
            @(posedge clk); #1;
            if (tog) bus.out_ready = !bus.out_ready;
            cyc++;
        end
        chk("done_timeout", 64'(cyc < 400), 64'd1);
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        chk("ptr_err", 64'(bus.ptr_err), 64'(err));
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("beats_left", 64'(expq.size()), 64'd0);
        chk("done_pulses", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        bus.start = 1'b0;
        bus.n_rows = '0;
        bus.out_ready = 1'b1;
        load(0);
        #12;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_ptr_err", 64'(bus.ptr_err), 64'd0);
        chk("rst_rp_en", 64'(bus.rp_en), 64'd0);
        chk("rst_nz_en", 64'(bus.nz_en), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_rp_addr", 64'(bus.rp_addr), 64'd0);
        chk("rst_nz_addr", 64'(bus.nz_addr), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // 3x3 matrix, ready held high
        load(0);
        run_pass(3, 1'b0);
        chk("t1_count", 64'(got.size()), 64'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("t1_lit", 64'(got[i]), 64'(LIT1[i]));

        // same matrix, ready toggling every cycle
        load(0);
        run_pass(3, 1'b1);
        chk("t2_count", 64'(got.size()), 64'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("t2_lit", 64'(got[i]), 64'(LIT1[i]));

        // empty middle row
        load(1);
        run_pass(3, 1'b0);
        chk("t3_count", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("t3_lit", 64'(got[i]), 64'(LIT3[i]));

        // n_rows == 0: done next cycle, nothing else moves
        @(posedge clk); #1;
        bus.start = 1'b1; bus.n_rows = '0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("n0_done", 64'(bus.done), 64'd1);
        chk("n0_busy", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("n0_quiet", 64'({bus.done, bus.busy, bus.rp_en, bus.nz_en}), 64'd0);
        end

        // backwards row pointer
        load(2);
        run_pass(3, 1'b0);
        chk("t5_ptr_err_lit", 64'(bus.ptr_err), 64'd1);
        chk("t5_count", 64'(got.size()), 64'd5);
        if (got.size() > 3) chk("t5_synthetic", 64'(got[3]), 64'(SYN_BAD));

        // reset after the second beat, then a full replay
        load(0);
        begin
            bit err;
            build_exp(3, err);
        end
        got.delete();
        acc = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.n_rows = 16'd3; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (acc < 2 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        chk("t6_two_beats_timeout", 64'(cyc < 100), 64'd1);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_busy", 64'(bus.busy), 64'd0);
        chk("t6_rst_done", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        run_pass(3, 1'b0);
        chk("t6_count", 64'(got.size()), 64'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("t6_lit", 64'(got[i]), 64'(LIT1[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
